en_dff_mux: RTL and testbench
=============================

// Module: en_dff_mux
// PURPOSE
//   Loadable storage slice: per bit, a 2:1 mux (mux2_1 function) chooses between holding the stored value and
//   loading the new input, feeding a D flip-flop (D_FF function).
//   Generic building block for CPU flag/status registers and small enabled registers.
//   A flag register is WIDTH=4 copies of this slice.
// PARAMETERS
//   WIDTH      4      number of independent bits (each = one mux2_1 + one D_FF)
//   RESET_VAL  '0     value loaded into q on reset (WIDTH bits)
// PORTS
//   clk      in   1      single clock; all state changes on rising edge only
//   reset    in   1      synchronous, active-low reset (0 = reset), sampled on rising clk
//   en       in   1      load enable: 1 = load d, 0 = hold q (mux select)
//   d        in   WIDTH  new data (mux w1 input)
//   q        out  WIDTH  stored value (D_FF q outputs; also mux w0 input)
//   mux_out  out  WIDTH  combinational next-state value = en ? d : q (mux out)
// BEHAVIOUR
//   - One clock domain, one synchronous, active-low reset; no asynchronous paths into state.
//   - Mux per bit: mux_out[i] = en ? d[i] : q[i]; purely combinational, zero-cycle.
//     en==X/Z must not be masked: mux_out follows standard 4-state evaluation.
//   - Flop per bit: at rising clk, q[i] <= (reset==0) ? RESET_VAL[i] : mux_out[i].
//   - Reset: q == RESET_VAL one edge after reset is sampled low; held while reset stays low.
//     Reset has priority over en and d.
//   - q before the first reset or load is undefined (X in simulation); no power-on init is required.
//   - Latency: load path is 1 cycle. d/en sampled at edge N; q updates after edge N and is stable until edge N+1.
//   - Hold: with en=0, q keeps its value indefinitely regardless of d toggling.
//   - Bits are independent; there is no carry or interaction between bit lanes.
//   - Reset release: the first edge with reset=1 and en=1 loads d.
//     With reset=1 and en=0, q stays RESET_VAL.
//   - Simultaneous en and d change before an edge: the values present at the edge win (standard setup semantics).
//   - No handshake, no backpressure, no FSM; pure registered storage with enable.
//   - Structural: implemented as a generate loop of WIDTH slices.
//     Each slice is a 2:1 mux feeding a D flip-flop, and q[i] is fed back to the mux w0 input.
//     Parameter checks: WIDTH >= 1 (elaboration error otherwise).
// TESTING
//   1 reset: reset=0 for 2 edges, any en/d -> q=0000 after first edge, stays 0000.
//   2 load: reset=1, en=1, d=0001 for 5 edges -> q=0001 after first edge;
//     mux_out=0001 combinationally.
//   3 hold: en=0, d=0010 for 5 edges -> q stays 0001; mux_out=0001.
//   4 reload: en=1, d=0010 -> q=0010 after next edge; mux_out=0010 immediately.
//   5 reset priority: q=0010, en=1, d=1111, reset=0 -> q=0000 next edge, held for 5 edges.
//     Release with en=0 -> q remains 0000.
//   6 per-bit independence: WIDTH=8, en=1, d=A5 then en=0, d=5A -> q=A5 held.
//     Checker compares q against a reference model every cycle.

Source files
------------

// File: rtl/en_dff_mux.sv
// Loadable storage slice: WIDTH independent lanes, each a 2:1 hold/load mux
// feeding a D flip-flop with synchronous active-low reset.
module en_dff_mux #(
    parameter int                 WIDTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] mux_out
);

    if (WIDTH < 1) begin : g_bad_width
        $error("en_dff_mux: WIDTH must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic bit_d;
        logic bit_q;

        // The ternary keeps 4-state semantics, so an X/Z select is not masked.
        always_comb begin
            bit_d = en ? d[i] : bit_q;
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                bit_q <= RESET_VAL[i];
            end else begin
                bit_q <= bit_d;
            end
        end

        assign mux_out[i] = bit_d;
        assign q[i]       = bit_q;
    end

endmodule

// File: tb/tb_en_dff_mux.sv
// Scoreboard bench for en_dff_mux: a 4-bit default instance and an 8-bit
// instance with a non-zero reset value share the same stimulus.
module tb_en_dff_mux;

    typedef struct packed {
        logic [3:0] q4;
        logic [7:0] q8;
    } exp_t;

    localparam logic [7:0] RV8 = 8'h3C;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] d;
    logic [3:0] q4, mux4;
    logic [7:0] q8, mux8;

    int n_checks = 0;
    int n_errors = 0;

    exp_t       sb[$];
    logic [3:0] m4;
    logic [7:0] m8;
    bit         mvalid = 1'b0;

    always #5 clk = ~clk;

    en_dff_mux dut4 (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .d       (d[3:0]),
        .q       (q4),
        .mux_out (mux4)
    );

    en_dff_mux #(.WIDTH(8), .RESET_VAL(RV8)) dut8 (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .d       (d),
        .q       (q8),
        .mux_out (mux8)
    );

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle: check the combinational mux, then the registered q.
    task automatic step(input string tag, input logic r, input logic e, input logic [7:0] dv);
        exp_t exp;
        exp_t got;
        @(negedge clk);
        reset = r;
        en    = e;
        d     = dv;
        #1;
        if (mvalid) begin
            check({tag, "/mux4"}, {4'h0, mux4}, {4'h0, (e ? dv[3:0] : m4)});
            check({tag, "/mux8"}, mux8, (e ? dv : m8));
        end
        @(posedge clk);
        if (!r) begin
            m4 = 4'h0;
            m8 = RV8;
        end else begin
            m4 = e ? dv[3:0] : m4;
            m8 = e ? dv : m8;
        end
        mvalid  = 1'b1;
        exp.q4  = m4;
        exp.q8  = m8;
        sb.push_back(exp);
        #1;
        got.q4 = q4;
        got.q8 = q8;
        if (sb.size() == 0) begin
            check({tag, "/sb_empty"}, 8'h00, 8'hFF);
        end else begin
            exp = sb.pop_front();
            check({tag, "/q4"}, {4'h0, got.q4}, {4'h0, exp.q4});
            check({tag, "/q8"}, got.q8, exp.q8);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        d     = '0;

        // reset for two edges with arbitrary en/d
        step("reset0", 1'b0, 1'b1, 8'hA7);
        step("reset1", 1'b0, 1'b0, 8'h5E);

        // first edge after release with en=1 loads d
        for (int i = 0; i < 5; i++) step("load", 1'b1, 1'b1, 8'h01);

        // hold with d changing underneath
        for (int i = 0; i < 5; i++) step("hold", 1'b1, 1'b0, 8'h02);
        step("hold_tgl", 1'b1, 1'b0, 8'hFD);

        step("reload", 1'b1, 1'b1, 8'h02);

        // reset beats en=1/d=FF, then release with en=0 keeps reset value
        for (int i = 0; i < 5; i++) step("rst_prio", 1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) step("rel_hold", 1'b1, 1'b0, 8'hFF);

        // X on en must propagate through the mux; reset still forces q
        step("en_x", 1'b0, 1'bx, 8'hF0);
        step("rel_load", 1'b1, 1'b1, 8'h33);

        // lane independence on the 8-bit instance
        step("lanes_ld", 1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < 5; i++) step("lanes_hold", 1'b1, 1'b0, 8'h5A);

        for (int i = 0; i < 40; i++) begin
            step("rand", ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)));
        end

        check("sb_drained", 8'(sb.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
